// File: rtl/sign_divide.sv
// sign_divide: sign-magnitude restoring divider, one quotient bit per clock.
// Ports: clk, rst (sync, active-high), start, a (sign+2N mag), b (sign+N mag)
//        -> q, q_sign, r, r_sign, busy, done (1-cycle pulse), div_zero.
module sign_divide #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N:0]   a,
    input  logic [N:0]     b,
    output logic [2*N-1:0] q,
    output logic           q_sign,
    output logic [N-1:0]   r,
    output logic           r_sign,
    output logic           busy,
    output logic           done,
    output logic           div_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CW = $clog2(2*N+1);
    localparam logic [CW-1:0] STEPS = CW'(2*N);

    logic [1:0]     state;
    logic [CW-1:0]  cnt;
    // Partial remainder; it is always below the divisor, so N bits suffice
    // between steps. The extra bit only exists transiently after the shift.
    logic [N-1:0]   rr;
    logic [2*N-1:0] qq;
    logic [N-1:0]   bmag;
    logic           asign;
    logic           bsign;

    logic [N:0]     sh;
    logic           ge;
    logic [N-1:0]   t;
    logic [N-1:0]   rn;
    logic [2*N-1:0] qn;

    // One restoring step: shift in the next dividend bit, try a subtract.
    always_comb begin
        sh = {rr, qq[2*N-1]};
        ge = (sh >= {1'b0, bmag});
        t  = sh[N-1:0] - bmag;
        rn = ge ? t : sh[N-1:0];
        qn = {qq[2*N-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rr       <= '0;
            qq       <= '0;
            bmag     <= '0;
            asign    <= 1'b0;
            bsign    <= 1'b0;
            q        <= '0;
            r        <= '0;
            q_sign   <= 1'b0;
            r_sign   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        asign <= a[2*N];
                        bsign <= b[N];
                        bmag  <= b[N-1:0];
                        if (b[N-1:0] == '0) begin
                            state    <= S_DONE;
                            q        <= '1;
                            r        <= '0;
                            q_sign   <= 1'b0;
                            r_sign   <= 1'b0;
                            div_zero <= 1'b1;
                            done     <= 1'b1;
                        end else begin
                            state    <= S_RUN;
                            rr       <= '0;
                            qq       <= a[2*N-1:0];
                            cnt      <= STEPS;
                            busy     <= 1'b1;
                            div_zero <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    rr  <= rn;
                    qq  <= qn;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state  <= S_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        q      <= qn;
                        r      <= rn;
                        // No negative zero on either result.
                        q_sign <= (asign ^ bsign) & (|qn);
                        r_sign <= asign & (|rn);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sign_divide.sv
// tb_sign_divide: directed scoreboard bench for sign_divide (N=4).
// Expected results come from an integer divide model pushed at each start.
module tb_sign_divide;

    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [2*N:0]   a;
    logic [N:0]     b;
    logic [2*N-1:0] q;
    logic           q_sign;
    logic [N-1:0]   r;
    logic           r_sign;
    logic           busy;
    logic           done;
    logic           div_zero;

    sign_divide #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .q(q), .q_sign(q_sign), .r(r), .r_sign(r_sign),
        .busy(busy), .done(done), .div_zero(div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] q;
        logic [3:0] r;
        logic       qs;
        logic       rs;
        logic       dz;
    } res_t;

    res_t sb[$];
    int   vecs = 0;
    int   errs = 0;
    int   lat;
    int   bc;
    int   n;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [8:0] av, input logic [4:0] bv);
        res_t e;
        int am, bm;
        am = int'(av[7:0]);
        bm = int'(bv[3:0]);
        if (bm == 0) begin
            e = '{q: 8'hFF, r: 4'd0, qs: 1'b0, rs: 1'b0, dz: 1'b1};
        end else begin
            e.q  = 8'(am / bm);
            e.r  = 4'(am % bm);
            e.qs = (av[8] ^ bv[4]) && (e.q != 0);
            e.rs = av[8] && (e.r != 0);
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic start_op(input logic [8:0] av, input logic [4:0] bv,
                            input bit push);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        if (push) sb.push_back(model(av, bv));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int l, output int bcount);
        l = 0;
        bcount = 0;
        while (done !== 1'b1 && l < 40) begin
            if (busy === 1'b1) bcount++;
            @(negedge clk);
            l++;
        end
    endtask

    task automatic check_out(input string tag);
        res_t e;
        chk({tag, ".done"}, 32'(done), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, ".q"}, 32'(q), 32'(e.q));
            chk({tag, ".r"}, 32'(r), 32'(e.r));
            chk({tag, ".q_sign"}, 32'(q_sign), 32'(e.qs));
            chk({tag, ".r_sign"}, 32'(r_sign), 32'(e.rs));
            chk({tag, ".div_zero"}, 32'(div_zero), 32'(e.dz));
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("reset.outs", 32'({q, r, q_sign, r_sign, busy, done, div_zero}), 32'd0);
        rst = 1'b0;

        // 1: +100 / +7
        start_op({1'b0, 8'd100}, {1'b0, 4'd7}, 1'b1);
        wait_done(lat, bc);
        check_out("t1");
        chk("t1.latency", 32'(lat), 32'd8);
        chk("t1.busy_cycles", 32'(bc), 32'd8);
        @(negedge clk);
        chk("t1.q_hold", 32'(q), 32'd14);
        chk("t1.done_pulse", 32'(done), 32'd0);

        // 2: sign combinations
        start_op({1'b1, 8'd100}, {1'b0, 4'd7}, 1'b1);
        wait_done(lat, bc);
        check_out("t2a");
        start_op({1'b1, 8'd100}, {1'b1, 4'd7}, 1'b1);
        wait_done(lat, bc);
        check_out("t2b");

        // 3: exact division, then negative zero dividend
        start_op({1'b0, 8'd255}, {1'b1, 4'd15}, 1'b1);
        wait_done(lat, bc);
        check_out("t3a");
        start_op({1'b1, 8'd0}, {1'b1, 4'd5}, 1'b1);
        wait_done(lat, bc);
        check_out("t3b");

        // 4: divide by (negative) zero, then a valid division
        start_op({1'b0, 8'd50}, {1'b1, 4'd0}, 1'b1);
        wait_done(lat, bc);
        check_out("t4a");
        chk("t4a.latency", 32'(lat), 32'd0);
        chk("t4a.busy_cycles", 32'(bc), 32'd0);
        start_op({1'b0, 8'd200}, {1'b0, 4'd9}, 1'b1);
        wait_done(lat, bc);
        check_out("t4b");

        // 5a: start pulse mid-run is ignored
        start_op({1'b0, 8'd100}, {1'b0, 4'd7}, 1'b1);
        repeat (2) @(negedge clk);
        a     = {1'b1, 8'd33};
        b     = {1'b0, 4'd2};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        check_out("t5a");
        chk("t5a.latency", 32'(lat + 3), 32'd8);

        // 5b: start held high, back-to-back
        @(negedge clk);
        a     = {1'b0, 8'd77};
        b     = {1'b0, 4'd3};
        start = 1'b1;
        sb.push_back(model(a, b));
        @(negedge clk);
        wait_done(lat, bc);
        check_out("t5b1");
        a = {1'b1, 8'd181};
        b = {1'b1, 4'd11};
        sb.push_back(model(a, b));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 40);
        start = 1'b0;
        check_out("t5b2");
        chk("t5b.spacing", 32'(n), 32'd10);

        // 6: reset mid-run aborts, then a fresh division
        start_op({1'b0, 8'd123}, {1'b0, 4'd5}, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6.abort_outs", 32'({q, r, q_sign, r_sign, busy, done, div_zero}), 32'd0);
        repeat (10) @(negedge clk);
        chk("t6.no_done", 32'({busy, done}), 32'd0);
        start_op({1'b1, 8'd123}, {1'b0, 4'd5}, 1'b1);
        wait_done(lat, bc);
        check_out("t6");
        chk("t6.latency", 32'(lat), 32'd8);

        chk("sb.drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
